queue_rr_arbiter: RTL and testbench
===================================

// Module: queue_rr_arbiter
// PURPOSE
//   Round-robin arbiter merging N_SRC valid/ready streams into one output stream
//   at burst granularity (one burst = BURST_LEN beats, e.g. one layernorm row).
//   A grant is held for a whole burst, so rows from different sources never interleave.
//   Sits in front of a shared queue / normalisation datapath. Tags each beat with
//   its source index and marks the final beat of each burst.
// PARAMETERS
//   N_SRC       4    number of requester streams (>= 1)
//   DATA_WIDTH  16   payload width per beat
//   BURST_LEN   8    beats per granted burst (>= 1)
// PORTS
//   clk   in   1                     clock, all state on rising edge
//   rst   in   1                     synchronous reset, active-high
//   idat  in   N_SRC*DATA_WIDTH      payload, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ivld  in   N_SRC                 per-source valid
//   irdy  out  N_SRC                 per-source ready (at most one bit set)
//   odat  out  DATA_WIDTH            output payload (registered)
//   osrc  out  max(1,$clog2(N_SRC))  source index of current output beat
//   olst  out  1                     high on final beat of a burst
//   ovld  out  1                     output valid
//   ordy  in   1                     output ready
// BEHAVIOUR
//   Reset: ovld=0, irdy=0, odat=0, osrc=0, olst=0, state=IDLE, beat counter=0,
//     last-grant pointer=N_SRC-1 (source 0 has top priority after reset).
//   Transfer rules: input beat on i when ivld[i]&&irdy[i]; output beat when ovld&&ordy.
//   Output register load enable bload = !ovld || ordy; one output register, no skid.
//   irdy[i] = (state==BUSY) && (gnt==i) && bload; combinational from state and ordy.
//   FSM:
//     IDLE: if any ivld, pick first set ivld[j] scanning j = ptr+1, ptr+2, ... mod N_SRC;
//       gnt<=j, ptr<=j, cnt<=0, -> BUSY next cycle. No ivld: stay IDLE.
//     BUSY: each accepted beat loads odat<=idat[gnt], osrc<=gnt, ovld<=1,
//       olst<=(cnt==BURST_LEN-1), cnt<=cnt+1. On accepted beat with cnt==BURST_LEN-1:
//       cnt<=0, -> IDLE. Otherwise stay BUSY even if ivld[gnt] drops (grant held,
//       other sources wait; no timeout).
//   If bload and no input accepted this cycle: ovld<=0.
//   Latency: input beat accepted at edge k is presented on odat/ovld from cycle k+1.
//   Throughput: 1 beat/cycle within a burst; exactly one IDLE bubble cycle between
//     bursts (arbitration cycle), also when the same source wins again.
//   Fairness: winner becomes lowest priority; a continuously requesting source waits
//     at most N_SRC-1 bursts.
//   Stall: ordy=0 with ovld=1 -> irdy all 0, odat/osrc/olst/ovld hold stable.
//   Counter: width max(1,$clog2(BURST_LEN)); BURST_LEN=1 -> every beat has olst=1.
//   N_SRC=1: osrc constant 0, behaves as burst-framed register stage.
//   Reset mid-burst: synchronous, abandons burst; next cycle matches reset state;
//     partial burst is not completed and no olst is emitted for it.
//   Simultaneous ordy and arbitration in IDLE: the pending output beat drains
//     independently of the FSM.
//   ivld/idat for non-granted sources are ignored; no combinational path idat->odat.
// TESTING
//   Reset, all ivld=1, ordy=1, N_SRC=4, BURST_LEN=8 -> bursts in source order
//     0,1,2,3,0; 8 beats each, olst on 8th, one ovld=0 cycle between bursts.
//   Only source 2 requests continuously -> bursts all osrc=2, 8 beats then 1 bubble,
//     repeating; irdy[0,1,3] stay 0.
//   Source 1 granted, ivld[1] drops for 3 cycles at beat 4 while source 3 requests
//     -> no beats from 3 until source 1 completes all 8 beats (olst on beat 8).
//   ordy held 0 for 5 cycles mid-burst -> ovld/odat/osrc/olst frozen, irdy=0;
//     on ordy=1 stream resumes with no beat lost or duplicated (check with counter data).
//   rst pulsed at beat 5 of a burst from source 1 -> next cycle ovld=0, irdy=0; after
//     release source 0 wins first if requesting, bursts again full 8 beats.
//   BURST_LEN=1, N_SRC=3, all requesting -> osrc 0,1,2,0 each with olst=1, bubble
//     between every beat.

Source files
------------

// File: rtl/queue_rr_arbiter_if.sv
// Stream bundle for queue_rr_arbiter: N_SRC request streams in, one tagged burst stream out.
// The master modport is the arbiter's view; slave is the surrounding fabric.
interface queue_rr_arbiter_if #(
    parameter int unsigned N_SRC      = 4,
    parameter int unsigned DATA_WIDTH = 16
);
    localparam int unsigned SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [N_SRC*DATA_WIDTH-1:0] idat;
    logic [N_SRC-1:0]            ivld;
    logic [N_SRC-1:0]            irdy;
    logic [DATA_WIDTH-1:0]       odat;
    logic [SRC_W-1:0]            osrc;
    logic                        olst;
    logic                        ovld;
    logic                        ordy;

    modport master (
        input  idat, ivld, ordy,
        output irdy, odat, osrc, olst, ovld
    );

    modport slave (
        output idat, ivld, ordy,
        input  irdy, odat, osrc, olst, ovld
    );
endinterface

// File: rtl/queue_rr_arbiter.sv
// Burst-granular round-robin arbiter: holds a grant for BURST_LEN beats, tags each beat
// with its source index and flags the final beat. Single registered output stage.
module queue_rr_arbiter #(
    parameter int unsigned N_SRC      = 4,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned BURST_LEN  = 8
) (
    input  logic               clk,
    input  logic               rst,
    queue_rr_arbiter_if.master bus
);
    localparam int unsigned SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int unsigned CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int          N_INT = int'(N_SRC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);
    localparam logic [SRC_W-1:0] SRC_LAST = SRC_W'(N_SRC - 1);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e                state_q;
    logic [SRC_W-1:0]      gnt_q;
    logic [SRC_W-1:0]      ptr_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] odat_q;
    logic [SRC_W-1:0]      osrc_q;
    logic                  olst_q;
    logic                  ovld_q;

    logic                  bload;
    logic                  sel_vld;
    logic [DATA_WIDTH-1:0] sel_dat;
    logic                  accept;
    logic [N_SRC-1:0]      irdy;
    logic                  arb_any;
    logic [SRC_W-1:0]      arb_win;

    assign bload  = !ovld_q || bus.ordy;
    assign accept = (state_q == StBusy) && bload && sel_vld;

    always_comb begin
        sel_vld = 1'b0;
        sel_dat = '0;
        irdy    = '0;
        for (int i = 0; i < N_INT; i++) begin
            if (gnt_q == SRC_W'(i)) begin
                sel_vld = bus.ivld[i];
                sel_dat = bus.idat[i*DATA_WIDTH +: DATA_WIDTH];
                irdy[i] = (state_q == StBusy) && bload;
            end
        end
    end

    // Scan starts just after the last winner, so the winner drops to lowest priority.
    always_comb begin
        arb_any = 1'b0;
        arb_win = '0;
        for (int k = 1; k <= N_INT; k++) begin
            for (int i = 0; i < N_INT; i++) begin
                if (!arb_any && bus.ivld[i] && (i == (int'(ptr_q) + k) % N_INT)) begin
                    arb_any = 1'b1;
                    arb_win = SRC_W'(i);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            ptr_q   <= SRC_LAST;
            cnt_q   <= '0;
            odat_q  <= '0;
            osrc_q  <= '0;
            olst_q  <= 1'b0;
            ovld_q  <= 1'b0;
        end else begin
            // The output register drains on its own, also while the FSM arbitrates.
            if (bload) begin
                if (accept) begin
                    odat_q <= sel_dat;
                    osrc_q <= gnt_q;
                    olst_q <= (cnt_q == CNT_LAST);
                    ovld_q <= 1'b1;
                end else begin
                    ovld_q <= 1'b0;
                end
            end
            unique case (state_q)
                StIdle: begin
                    if (arb_any) begin
                        gnt_q   <= arb_win;
                        ptr_q   <= arb_win;
                        cnt_q   <= '0;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    if (accept) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q   <= '0;
                            state_q <= StIdle;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.irdy = irdy;
    assign bus.odat = odat_q;
    assign bus.osrc = osrc_q;
    assign bus.olst = olst_q;
    assign bus.ovld = ovld_q;
endmodule

// File: tb/tb_queue_rr_arbiter.sv
// Bench for queue_rr_arbiter: directed phases pinned by literal timelines, then random traffic
// checked every cycle against a transaction-level round-robin model.
module tb_queue_rr_arbiter;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int BL = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    queue_rr_arbiter_if #(.N_SRC(N), .DATA_WIDTH(DW)) bus_a ();
    queue_rr_arbiter_if #(.N_SRC(3), .DATA_WIDTH(8))  bus_b ();

    queue_rr_arbiter #(.N_SRC(N), .DATA_WIDTH(DW), .BURST_LEN(BL)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    queue_rr_arbiter #(.N_SRC(3), .DATA_WIDTH(8), .BURST_LEN(1)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: burst in progress (who, how many beats so far), last winner, output beat held.
    bit            m_busy;
    int            m_gnt;
    int            m_last;
    int            m_beats;
    bit            m_ovld;
    logic [DW-1:0] m_odat;
    int            m_osrc;
    bit            m_olst;
    int            seq [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] data_of(input int i);
        return DW'((i << 12) | (seq[i] & 'hfff));
    endfunction

    function automatic int pick(input int last, input logic [N-1:0] req);
        for (int k = 1; k <= N; k++) begin
            if (req[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_irdy();
        logic [N-1:0] one;
        one = 1;
        if (m_busy && (!m_ovld || bus_a.ordy)) return one << m_gnt;
        return '0;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_gnt = 0; m_last = N - 1; m_beats = 0;
        m_ovld = 0; m_odat = '0; m_osrc = 0; m_olst = 0;
    endtask

    task automatic drive(input logic [N-1:0] v, input logic r, input logic o);
        rst        = r;
        bus_a.ivld = v;
        bus_a.ordy = o;
        for (int i = 0; i < N; i++) bus_a.idat[i*DW +: DW] = data_of(i);
    endtask

    // Compare DUT against the model, then advance the model across the next edge.
    task automatic compare_and_advance();
        logic [N-1:0]  er;
        bit            took;
        int            w;
        logic [DW-1:0] d;
        er = exp_irdy();
        chk("irdy", 32'(bus_a.irdy), 32'(er));
        chk("ovld", 32'(bus_a.ovld), 32'(m_ovld));
        chk("odat", 32'(bus_a.odat), 32'(m_odat));
        chk("osrc", 32'(bus_a.osrc), 32'(m_osrc));
        chk("olst", 32'(bus_a.olst), 32'(m_olst));
        took = m_busy && er[m_gnt] && bus_a.ivld[m_gnt];
        d    = data_of(m_gnt);
        for (int i = 0; i < N; i++) if (er[i] && bus_a.ivld[i]) seq[i]++;
        if (rst) begin
            model_reset();
        end else begin
            if (!m_ovld || bus_a.ordy) begin
                if (took) begin
                    m_ovld = 1; m_odat = d; m_osrc = m_gnt; m_olst = (m_beats == BL - 1);
                end else begin
                    m_ovld = 0;
                end
            end
            if (!m_busy) begin
                w = pick(m_last, bus_a.ivld);
                if (w >= 0) begin
                    m_busy = 1; m_gnt = w; m_last = w; m_beats = 0;
                end
            end else if (took) begin
                m_beats++;
                if (m_beats == BL) begin
                    m_busy = 0; m_beats = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0] v;
        logic         o;
        logic         r;
        logic         lv;
        logic         lb;
        int           stall;

        for (int i = 0; i < N; i++) seq[i] = 0;
        bus_b.ivld = 3'b111;
        bus_b.ordy = 1'b1;
        bus_b.idat = 24'h030201;
        drive('0, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        #3;
        chk("rst_ovld", 32'(bus_a.ovld), 32'd0);
        chk("rst_irdy", 32'(bus_a.irdy), 32'd0);
        chk("rst_odat", 32'(bus_a.odat), 32'd0);
        chk("rst_osrc", 32'(bus_a.osrc), 32'd0);
        chk("rst_olst", 32'(bus_a.olst), 32'd0);
        chk("rst_b_ovld", 32'(bus_b.ovld), 32'd0);
        compare_and_advance();

        // All sources requesting: bursts 0,1,2,3,0 with one bubble each (period 9 cycles).
        for (int c = 0; c < 45; c++) begin
            drive('1, 1'b0, 1'b1);
            #3;
            lv = (c >= 2) && ((c - 2) % 9 < 8);
            chk("p1_ovld", 32'(bus_a.ovld), 32'(lv));
            if (lv) begin
                chk("p1_osrc", 32'(bus_a.osrc), 32'(((c - 2) / 9) % 4));
                chk("p1_olst", 32'(bus_a.olst), 32'((c - 2) % 9 == 7));
            end
            if (c >= 2 && c < 10) chk("p1_odat", 32'(bus_a.odat), 32'(c - 2));
            if (c < 12) begin
                lb = (c >= 2) && (c % 2 == 0);
                chk("b_ovld", 32'(bus_b.ovld), 32'(lb));
                if (lb) begin
                    chk("b_osrc", 32'(bus_b.osrc), 32'(((c - 2) / 2) % 3));
                    chk("b_olst", 32'(bus_b.olst), 32'd1);
                end
            end
            compare_and_advance();
        end

        // Only source 2 requests.
        for (int c = 0; c < 40; c++) begin
            drive(4'b0100, 1'b0, 1'b1);
            #3;
            chk("p2_irdy_others", 32'(bus_a.irdy & 4'b1011), 32'd0);
            if (c >= 2 && bus_a.ovld) chk("p2_osrc", 32'(bus_a.osrc), 32'd2);
            compare_and_advance();
        end

        // Reset during beat 5 of a source-1 burst, then everyone requests.
        drive('0, 1'b1, 1'b1);
        #3;
        compare_and_advance();
        for (int c = 0; c < 21; c++) begin
            drive((c <= 6) ? 4'b0010 : 4'b1111, (c == 6), 1'b1);
            #3;
            if (c == 6) chk("p3_pre_osrc", 32'(bus_a.osrc), 32'd1);
            if (c == 7) begin
                chk("p3_rst_ovld", 32'(bus_a.ovld), 32'd0);
                chk("p3_rst_irdy", 32'(bus_a.irdy), 32'd0);
            end
            if (c == 9) chk("p3_first_src", 32'(bus_a.osrc), 32'd0);
            if (c == 16) chk("p3_olst", 32'(32'(bus_a.olst) | (32'(bus_a.osrc) << 4)), 32'h1);
            compare_and_advance();
        end

        // Random traffic, output stalls and occasional resets.
        stall = 0;
        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 9) < 6);
            if (stall > 0) begin
                o = 1'b0;
                stall--;
            end else begin
                o = ($urandom_range(0, 9) < 7);
                if ($urandom_range(0, 49) == 0) stall = 5;
            end
            r = ($urandom_range(0, 399) == 0);
            drive(v, r, o);
            #3;
            compare_and_advance();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
